// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: run/halt state, next-PC select codes
// and the sequential step size.
package pc_sequencer_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int          NUM_PATHS = 4;
  localparam int          PC_W      = 32;
  localparam logic [1:0]  SEL_SEQ   = 2'd0;
  localparam logic [1:0]  SEL_BR    = 2'd1;
  localparam logic [1:0]  SEL_J     = 2'd2;
  localparam logic [1:0]  SEL_JR    = 2'd3;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_sequencer_sel.sv
// 32-bit four-path next-PC selector; candidate index equals the select code.
module pc_sequencer_sel
  import pc_sequencer_pkg::*;
(
  input  logic [NUM_PATHS-1:0][PC_W-1:0] cand,
  input  logic [1:0]                     sel,
  output logic [PC_W-1:0]                y
);

  always_comb begin
    y = cand[SEL_SEQ];
    case (sel)
      SEL_BR:  y = cand[SEL_BR];
      SEL_J:   y = cand[SEL_J];
      SEL_JR:  y = cand[SEL_JR];
      default: y = cand[SEL_SEQ];
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential/branch/jump/register targets, halt/resume,
// sticky misaligned-JR flag and run/advance counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        addr_err,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  state_t                         state, state_nxt;
  logic [NUM_PATHS-1:0][PC_W-1:0] cand;
  logic [1:0]                     sel;
  logic [31:0]                    pc_sel, pc_nxt;
  logic                           ic_inc, cc_inc, err_set;

  assign pc_plus4 = pc + PC_STEP;
  assign halted   = (state == HALT);

  assign cand[SEL_SEQ] = pc_plus4;
  assign cand[SEL_BR]  = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign cand[SEL_J]   = {pc_plus4[31:28], jump_index, 2'b00};
  assign cand[SEL_JR]  = {jr_addr[31:2], 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (jr)                sel = SEL_JR;
    else if (jump)         sel = SEL_J;
    else if (branch_taken) sel = SEL_BR;
  end

  pc_sequencer_sel u_sel (
    .cand (cand),
    .sel  (sel),
    .y    (pc_sel)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ic_inc    = 1'b0;
    cc_inc    = 1'b0;
    err_set   = 1'b0;
    case (state)
      RUN: begin
        cc_inc = 1'b1;
        // halt_req wins over any redirect, but only when not stalled
        if (!stall) begin
          if (halt_req) begin
            state_nxt = HALT;
          end else begin
            pc_nxt  = pc_sel;
            ic_inc  = 1'b1;
            err_set = (sel == SEL_JR) && (jr_addr[1:0] != 2'b00);
          end
        end
      end
      HALT: begin
        if (resume) begin
          state_nxt = RUN;
          pc_nxt    = pc_plus4;
          ic_inc    = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      addr_err  <= 1'b0;
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      addr_err  <= addr_err | err_set;
      cycle_cnt <= cycle_cnt + {31'd0, cc_inc};
      instr_cnt <= instr_cnt + {31'd0, ic_inc};
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port stall, input, 1: hold PC this cycle (downstream hazard).
REQ-005 SHALL have port branch_taken, input, 1: conditional branch resolved taken.
REQ-006 SHALL have port branch_offset, input, 16: signed word offset from the branch instruction.
REQ-007 SHALL have port jump, input, 1: J/JAL in flight.
REQ-008 SHALL have port jump_index, input, 26: J-format target field.
REQ-009 SHALL have port jr, input, 1: JR/JALR in flight.
REQ-010 SHALL have port jr_addr, input, 32: register-sourced target.
REQ-011 SHALL have port halt_req, input, 1: syscall/halt decoded.
REQ-012 SHALL have port resume, input, 1: restart after halt.
REQ-013 SHALL have port pc, output, 32: current fetch address.
REQ-014 SHALL have port pc_plus4, output, 32: pc+4 (link value).
REQ-015 SHALL have port halted, output, 1: high in HALT state.
REQ-016 SHALL have port addr_err, output, 1: sticky misaligned-JR flag.
REQ-017 SHALL have port cycle_cnt, output, 32: cycles spent in RUN.
REQ-018 SHALL have port instr_cnt, output, 32: PC advances.

Function
REQ-019 SHALL form candidate 0 = pc+4; candidate 1 = pc+4 + (sign-extended branch_offset << 2); candidate 2 = {pc_plus4[31:28], jump_index, 2'b00}; candidate 3 = {jr_addr[31:2], 2'b00}; all arithmetic modulo 2^32.
REQ-020 SHALL select priority jr > jump > branch_taken > sequential, encoded 3/2/1/0.
REQ-021 SHALL implement states RUN and HALT only.
REQ-022 In RUN with stall=1: pc, state and instr_cnt SHALL hold; halt_req, jr, jump and branch_taken are ignored; cycle_cnt increments.
REQ-023 In RUN with stall=0 and halt_req=0: pc SHALL load the selected candidate at the next edge; instr_cnt increments.
REQ-024 In RUN with stall=0 and halt_req=1: state SHALL go to HALT, pc holds, and instr_cnt does not increment (halt_req beats jr/jump/branch).
REQ-025 In HALT: pc, cycle_cnt and instr_cnt SHALL hold; all inputs except resume are ignored.
REQ-026 In HALT with resume=1: state SHALL go to RUN, pc <= pc+4, and instr_cnt increments; that edge does not increment cycle_cnt.
REQ-027 resume SHALL have no effect in RUN.
REQ-028 addr_err SHALL set at the edge where candidate 3 is loaded with jr_addr[1:0] != 0, and clear only on reset.
REQ-029 Counters SHALL wrap 32'hFFFF_FFFF -> 0 without flag.
REQ-030 pc_plus4 and halted SHALL be combinational from registered state; no input-to-pc combinational path.

Reset
REQ-031 rst_n low SHALL immediately set pc=RESET_PC, state=RUN, halted=0, addr_err=0, cycle_cnt=0, instr_cnt=0, regardless of clock or state (including mid-HALT).
REQ-032 The first edge after rst_n deasserts SHALL behave as a normal RUN edge.

Structure
REQ-033 Shared package SHALL hold the state encoding (RUN=1'b0, HALT=1'b1), the select codes SEL_SEQ=0, SEL_BR=1, SEL_J=2, SEL_JR=3, and constant PC_STEP=4.
REQ-034 Next-PC selection SHALL reuse the existing 32-bit four-path selector as the one sub-module; all other logic is inline.

Verification
REQ-035 Reset: RESET_PC=32'h0000_3000, rst_n low mid-run -> pc=32'h0000_3000, counters 0; after release, three free cycles -> pc=32'h0000_300C, instr_cnt=3.
REQ-036 Branch: pc=32'h0000_3010, branch_taken=1, offset=16'hFFFC -> pc=32'h0000_3004; offset=16'h0002 -> pc=32'h0000_301C.
REQ-037 Priority: pc=32'h0000_3000, jr=1 with jr_addr=32'h0000_4002, jump=1, branch_taken=1 all set -> pc=32'h0000_4000, addr_err=1.
REQ-038 Halt: halt_req at pc=32'h0000_3020 -> halted=1, pc held for 5 cycles, counters frozen; resume -> pc=32'h0000_3024, halted=0.
REQ-039 Stall vs halt: stall=1 and halt_req=1 in the same cycle -> still RUN, pc held, cycle_cnt +1, instr_cnt unchanged.
REQ-040 Wrap: force instr_cnt to 32'hFFFF_FFFF, one advance -> instr_cnt=0; pc=32'hFFFF_FFFC sequential -> pc=32'h0000_0000.
